rf_writeback_arbiter: RTL



---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_writeback_arbiter_if.sv | 21 ++
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/rf_writeback_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions for the writeback slice.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : geometry of the 32x32 register file
//   ZERO_REG                          : hard-wired zero register, writes to it are dropped
//   wb_req_t                          : one pending register write (destination + value)
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Valid/ready result channel from one producer (ALU or LSU) into the
// writeback arbiter.
//   valid : producer has a result this cycle
//   ready : arbiter accepts the beat this cycle
//   addr  : destination register
//   data  : result value
// master = producer side, slave = arbiter side.
interface rf_writeback_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of pending register writes (ALU results that lost
// write-port arbitration).
//   clk, rst     : clock, synchronous active-high reset (flushes all entries)
//   push, push_req : enqueue one request (ignored when full)
//   pop          : dequeue the head (ignored when empty)
//   full, empty  : occupancy flags
//   head         : oldest entry
//   entry_valid, entry_addr : per-slot occupancy and destination, used by
//                  the parent to build the register busy mask
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_req,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output wb_req_t               head,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [REG_ADDR_W-1:0] entry_addr [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [DEPTH-1:0]   valid_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: only slots flagged in valid_q are ever read
    // meaningfully.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
    // A slot is cleared on pop before being set on push; the two can only
    // address the same slot when the FIFO is empty or full, which the
    // do_push/do_pop guards already exclude.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                valid_q[wr_ptr] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign entry_valid = valid_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter in front of the register file's single write port.
//   elk, nrst : clock, synchronous active-high reset
//   alu       : single-cycle ALU result channel (slave side)
//   lsu       : variable-latency load result channel (slave side)
//   wr_en / wr_addr / wr_data : registered register-file write port
//   busy_mask : bit n set while a write to register n is still in flight
// ALU results that lose the write port are parked in wb_fifo. Writes to the
// zero register are accepted and then silently dropped.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int DATA_W     = REG_DATA_W
) (
    input  logic                     elk,
    input  logic                     nrst,
    rf_writeback_arbiter_if.slave    alu,
    rf_writeback_arbiter_if.slave    lsu,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [2**ADDR_W-1:0]     busy_mask
);

    logic                  fifo_full;
    logic                  fifo_empty;
    wb_req_t               fifo_head;
    logic [FIFO_DEPTH-1:0] entry_valid;
    logic [REG_ADDR_W-1:0] entry_addr [FIFO_DEPTH];
    logic                  fifo_push;
    logic                  fifo_pop;
    wb_req_t               alu_req;
    logic                  accept_rdy;
    logic                  alu_take;
    logic                  lsu_take;
    logic                  win_valid;
    wb_req_t               win_req;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (elk),
        .rst         (nrst),
        .push        (fifo_push),
        .push_req    (alu_req),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Readies depend only on state (and reset), never on the valids.
    assign accept_rdy = !nrst && !fifo_full;
    assign alu.ready  = accept_rdy;
    assign lsu.ready  = accept_rdy;

    // Zero-register beats still handshake but never become candidates, so
    // they cannot block the FIFO or a bypassing ALU beat.
    assign alu_take = alu.valid && accept_rdy && (alu.addr != ADDR_W'(ZERO_REG));
    assign lsu_take = lsu.valid && accept_rdy && (lsu.addr != ADDR_W'(ZERO_REG));
    assign alu_req  = '{addr: alu.addr, data: alu.data};

    // Priority: full FIFO drains first, then LSU, then the FIFO head, then an
    // ALU bypass. An accepted ALU beat that is not the winner is enqueued;
    // that can never coincide with a full FIFO because the readies are low.
    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        win_valid = 1'b0;
        win_req   = '0;
        if (fifo_full) begin
            win_valid = 1'b1;
            win_req   = fifo_head;
            fifo_pop  = 1'b1;
        end else if (lsu_take) begin
            win_valid = 1'b1;
            win_req   = '{addr: lsu.addr, data: lsu.data};
            fifo_push = alu_take;
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_req   = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = alu_take;
        end else if (alu_take) begin
            win_valid = 1'b1;
            win_req   = alu_req;
        end
    end

    // Registered write port: the winner is presented one edge later.
    always_ff @(posedge elk) begin
        if (nrst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= win_valid;
            if (win_valid) begin
                wr_addr <= win_req.addr;
                wr_data <= win_req.data;
            end
        end
    end

    // Everything parked in the FIFO plus the write on the port this cycle.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy_mask[entry_addr[i]] = 1'b1;
            end
        end
        if (wr_en) begin
            busy_mask[wr_addr] = 1'b1;
        end
        busy_mask[ZERO_REG] = 1'b0;
    end

endmodule
